hamming_secded_pipe: RTL and testbench

//  Parametrised, pipelined Hamming SECDED decoder. Successor to the combinational
//  7,4 corrector: it generalises the data width and adds an overall parity bit
//  for double-error detection. It adds a valid/ready stream handshake with

---
 rtl/hamming_secded_pipe_if.sv | 35 +++
 rtl/hamming_secded_pipe.sv | 168 ++++++++++++++++
 tb/tb_hamming_secded_pipe.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/hamming_secded_pipe_if.sv
// ----------------------------------------------------------------------------
// hamming_secded_pipe_if : codeword-in / decoded-word-out stream bundle
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface hamming_secded_pipe_if #(
  parameter int DATA_W   = 4,
  parameter int PARITY_W = 3
);
  localparam int N = DATA_W + PARITY_W;

  logic                in_valid;
  logic                in_ready;
  logic [N:0]          code_in;
  logic                correct_en;
  logic                out_valid;
  logic                out_ready;
  logic [DATA_W-1:0]   data_out;
  logic [PARITY_W-1:0] syndrome;
  logic                err_single;
  logic                err_double;

  modport master (
    output in_valid, code_in, correct_en, out_ready,
    input  in_ready, out_valid, data_out, syndrome, err_single, err_double
  );

  modport slave (
    input  in_valid, code_in, correct_en, out_ready,
    output in_ready, out_valid, data_out, syndrome, err_single, err_double
  );
endinterface

`default_nettype wire

// File: rtl/hamming_secded_pipe.sv
// ----------------------------------------------------------------------------
// hamming_secded_pipe : 2-stage Hamming SECDED decoder, valid/ready, error counters
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module hamming_secded_pipe #(
  parameter int DATA_W   = 4,
  parameter int PARITY_W = 3,
  parameter int CNT_W    = 8
) (
  input  wire logic               clk,
  input  wire logic               rst_n,
  hamming_secded_pipe_if.slave    io,
  input  wire logic               cnt_clr,
  output logic [CNT_W-1:0]        cnt_single,
  output logic [CNT_W-1:0]        cnt_double
);
  localparam int                  N       = DATA_W + PARITY_W;
  localparam logic [PARITY_W:0]   N_POS   = (PARITY_W + 1)'(N);
  localparam logic [CNT_W-1:0]    CNT_MAX = '1;

  if ((2 ** PARITY_W) < (N + 1)) begin : g_param_check
    $error("PARITY_W too small for DATA_W");
  end

  // 1-based codeword position holding data bit d (d-th non-power-of-two).
  function automatic int data_pos(input int d);
    int cnt;
    int pos;
    cnt = 0;
    pos = 1;
    for (int p = 1; p <= N; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (cnt == d) pos = p;
        cnt++;
      end
    end
    return pos;
  endfunction

  logic                s2_adv, s1_adv, s1_take, xfer;
  logic                s1_valid_q, s1_valid_d;
  logic [DATA_W-1:0]   s1_data_q, s1_data_d, data_raw, data_fix;
  logic                s1_corr_q, s1_corr_d;
  logic [PARITY_W-1:0] s1_syn_q, s1_syn_d, syn_in;
  logic                s1_par_q, s1_par_d;
  logic                out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [PARITY_W-1:0] syn_q, syn_d;
  logic                err_single_q, err_single_d, err_double_q, err_double_d;
  logic [CNT_W-1:0]    cnt_single_q, cnt_single_d, cnt_double_q, cnt_double_d;
  logic                syn_nz, pos_ok, is_single, is_double, do_fix;

  assign s2_adv      = !out_valid_q | io.out_ready;
  assign s1_adv      = !s1_valid_q | s2_adv;
  assign s1_take     = rst_n & s1_adv & io.in_valid;
  assign io.in_ready = rst_n & s1_adv;
  assign xfer        = out_valid_q & io.out_ready;

  always_comb begin
    syn_in = '0;
    for (int p = 1; p <= N; p++) begin
      if (io.code_in[p-1]) syn_in = syn_in ^ PARITY_W'(p);
    end
  end

  // Parity positions are fully summarised by syndrome and P, so S1 keeps only data bits.
  for (genvar d = 0; d < DATA_W; d++) begin : g_gather
    assign data_raw[d] = io.code_in[data_pos(d) - 1];
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s1_corr_d  = s1_corr_q;
    s1_syn_d   = s1_syn_q;
    s1_par_d   = s1_par_q;
    if (s1_adv) begin
      s1_valid_d = s1_take;
      if (s1_take) begin
        s1_data_d = data_raw;
        s1_corr_d = io.correct_en;
        s1_syn_d  = syn_in;
        s1_par_d  = ^io.code_in;
      end
    end
  end

  assign syn_nz    = |s1_syn_q;
  assign pos_ok    = {1'b0, s1_syn_q} <= N_POS;
  assign is_single = s1_par_q & (!syn_nz | pos_ok);
  assign is_double = syn_nz & (!s1_par_q | !pos_ok);
  assign do_fix    = s1_corr_q & s1_par_q & syn_nz & pos_ok;

  for (genvar d = 0; d < DATA_W; d++) begin : g_extract
    assign data_fix[d] = s1_data_q[d] ^ (do_fix & (s1_syn_q == PARITY_W'(data_pos(d))));
  end

  always_comb begin
    out_valid_d  = out_valid_q;
    data_d       = data_q;
    syn_d        = syn_q;
    err_single_d = err_single_q;
    err_double_d = err_double_q;
    if (s2_adv) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        data_d       = data_fix;
        syn_d        = s1_syn_q;
        err_single_d = is_single;
        err_double_d = is_double;
      end
    end
  end

  always_comb begin
    cnt_single_d = cnt_single_q;
    cnt_double_d = cnt_double_q;
    if (cnt_clr) begin
      cnt_single_d = '0;
      cnt_double_d = '0;
    end else if (xfer) begin
      if (err_single_q && cnt_single_q != CNT_MAX) cnt_single_d = cnt_single_q + CNT_W'(1);
      if (err_double_q && cnt_double_q != CNT_MAX) cnt_double_d = cnt_double_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q   <= 1'b0;
      s1_data_q    <= '0;
      s1_corr_q    <= 1'b0;
      s1_syn_q     <= '0;
      s1_par_q     <= 1'b0;
      out_valid_q  <= 1'b0;
      data_q       <= '0;
      syn_q        <= '0;
      err_single_q <= 1'b0;
      err_double_q <= 1'b0;
      cnt_single_q <= '0;
      cnt_double_q <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_data_q    <= s1_data_d;
      s1_corr_q    <= s1_corr_d;
      s1_syn_q     <= s1_syn_d;
      s1_par_q     <= s1_par_d;
      out_valid_q  <= out_valid_d;
      data_q       <= data_d;
      syn_q        <= syn_d;
      err_single_q <= err_single_d;
      err_double_q <= err_double_d;
      cnt_single_q <= cnt_single_d;
      cnt_double_q <= cnt_double_d;
    end
  end

  assign io.out_valid  = out_valid_q;
  assign io.data_out   = data_q;
  assign io.syndrome   = syn_q;
  assign io.err_single = err_single_q;
  assign io.err_double = err_double_q;
  assign cnt_single    = cnt_single_q;
  assign cnt_double    = cnt_double_q;
endmodule

`default_nettype wire

// File: tb/tb_hamming_secded_pipe.sv
// ----------------------------------------------------------------------------
// tb_hamming_secded_pipe : directed vectors with hand-computed SECDED results
// Rev 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_hamming_secded_pipe;
  localparam int DATA_W   = 4;
  localparam int PARITY_W = 3;
  localparam int CNT_W    = 8;

  typedef struct packed {
    logic [7:0] code;
    logic       corr;
    logic [3:0] data;
    logic [2:0] syn;
    logic       se;
    logic       de;
  } vec_t;

  typedef struct packed {
    vec_t v;
    int   acc;
  } pend_t;

  logic             clk     = 1'b0;
  logic             rst_n   = 1'b0;
  logic             cnt_clr = 1'b0;
  logic [CNT_W-1:0] cnt_single, cnt_double;

  hamming_secded_pipe_if #(.DATA_W(DATA_W), .PARITY_W(PARITY_W)) bus ();

  hamming_secded_pipe #(.DATA_W(DATA_W), .PARITY_W(PARITY_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .io         (bus),
    .cnt_clr    (cnt_clr),
    .cnt_single (cnt_single),
    .cnt_double (cnt_double)
  );

  always #5 clk = ~clk;

  vec_t       tbl [13];
  vec_t       cur;
  pend_t      q [$];
  int         n_vec = 0;
  int         n_err = 0;
  int         cyc   = 0;
  logic       lat_chk = 1'b0;
  logic       saw_bp  = 1'b0;
  logic       stall_q = 1'b0;
  logic [7:0] m_cs = '0, m_cd = '0;
  logic [3:0] h_data;
  logic [2:0] h_syn;
  logic       h_se, h_de;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input int idx);
    logic acc;
    int   n;
    cur            = tbl[idx];
    bus.code_in    = tbl[idx].code;
    bus.correct_en = tbl[idx].corr;
    bus.in_valid   = 1'b1;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) chk_eq("send_timeout", 32'(acc), 32'd1);
  endtask

  task automatic drain();
    int n;
    bus.in_valid = 1'b0;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      cycles(1);
      n++;
    end
    cycles(1);
    chk_eq("drain", 32'(q.size()), 32'd0);
  endtask

  // Scoreboard plus counter model, evaluated mid-cycle with inputs settled.
  initial forever begin
    pend_t p;
    @(negedge clk);
    cyc++;
    if (!rst_n) begin
      q.delete();
      m_cs    = '0;
      m_cd    = '0;
      stall_q = 1'b0;
    end else begin
      chk_eq("cnt_single", 32'(cnt_single), 32'(m_cs));
      chk_eq("cnt_double", 32'(cnt_double), 32'(m_cd));
      if (stall_q) begin
        chk_eq("stall_valid", 32'(bus.out_valid), 32'd1);
        chk_eq("stall_data", 32'(bus.data_out), 32'(h_data));
        chk_eq("stall_syn", 32'(bus.syndrome), 32'(h_syn));
        chk_eq("stall_flags", 32'({bus.err_single, bus.err_double}), 32'({h_se, h_de}));
      end
      if (bus.in_valid && !bus.in_ready) saw_bp = 1'b1;
      if (bus.in_valid && bus.in_ready) begin
        p.v   = cur;
        p.acc = cyc;
        q.push_back(p);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) begin
          chk_eq("spurious_out", 32'(q.size()), 32'd1);
        end else begin
          p = q.pop_front();
          chk_eq("data_out", 32'(bus.data_out), 32'(p.v.data));
          chk_eq("syndrome", 32'(bus.syndrome), 32'(p.v.syn));
          chk_eq("err_single", 32'(bus.err_single), 32'(p.v.se));
          chk_eq("err_double", 32'(bus.err_double), 32'(p.v.de));
          if (lat_chk) chk_eq("latency", 32'(cyc - p.acc), 32'd2);
          if (!cnt_clr) begin
            if (p.v.se && m_cs != 8'hFF) m_cs++;
            if (p.v.de && m_cd != 8'hFF) m_cd++;
          end
        end
      end
      if (cnt_clr) begin
        m_cs = '0;
        m_cd = '0;
      end
      stall_q = bus.out_valid & !bus.out_ready;
      h_data  = bus.data_out;
      h_syn   = bus.syndrome;
      h_se    = bus.err_single;
      h_de    = bus.err_double;
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, n_err=%0d", n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    //               code   corr  data     syn   se    de
    tbl[0]  = '{8'h55, 1'b1, 4'b1011, 3'd0, 1'b0, 1'b0};
    tbl[1]  = '{8'h45, 1'b1, 4'b1011, 3'd5, 1'b1, 1'b0};
    tbl[2]  = '{8'h45, 1'b0, 4'b1001, 3'd5, 1'b1, 1'b0};
    tbl[3]  = '{8'h56, 1'b1, 4'b1011, 3'd3, 1'b0, 1'b1};
    tbl[4]  = '{8'hD5, 1'b1, 4'b1011, 3'd0, 1'b1, 1'b0};
    tbl[5]  = '{8'h00, 1'b1, 4'b0000, 3'd0, 1'b0, 1'b0};
    tbl[6]  = '{8'hFF, 1'b1, 4'b1111, 3'd0, 1'b0, 1'b0};
    tbl[7]  = '{8'hBF, 1'b1, 4'b1111, 3'd7, 1'b1, 1'b0};
    tbl[8]  = '{8'h04, 1'b1, 4'b0000, 3'd3, 1'b1, 1'b0};
    tbl[9]  = '{8'h04, 1'b0, 4'b0001, 3'd3, 1'b1, 1'b0};
    tbl[10] = '{8'h09, 1'b1, 4'b0000, 3'd5, 1'b0, 1'b1};
    tbl[11] = '{8'h80, 1'b1, 4'b0000, 3'd0, 1'b1, 1'b0};
    tbl[12] = '{8'hBF, 1'b0, 4'b0111, 3'd7, 1'b1, 1'b0};
    cur            = tbl[0];
    bus.in_valid   = 1'b0;
    bus.code_in    = '0;
    bus.correct_en = 1'b0;
    bus.out_ready  = 1'b1;

    #12;
    chk_eq("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk_eq("rst_data", 32'(bus.data_out), 32'd0);
    chk_eq("rst_syn", 32'(bus.syndrome), 32'd0);
    chk_eq("rst_flags", 32'({bus.err_single, bus.err_double}), 32'd0);
    chk_eq("rst_cnts", 32'({cnt_single, cnt_double}), 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    #1 chk_eq("in_ready_release", 32'(bus.in_ready), 32'd1);
    cycles(1);

    // Single-word latency, then every table vector back to back
    lat_chk = 1'b1;
    send(0);
    drain();
    for (int i = 1; i < 13; i++) send(i);
    drain();

    // Stream of 10 with a 4-cycle consumer stall
    lat_chk = 1'b0;
    saw_bp  = 1'b0;
    fork
      begin
        for (int i = 0; i < 10; i++) send(i);
        bus.in_valid = 1'b0;
      end
      begin
        cycles(3);
        bus.out_ready = 1'b0;
        cycles(4);
        bus.out_ready = 1'b1;
      end
    join
    drain();
    chk_eq("backpressure_seen", 32'(saw_bp), 32'd1);

    // Saturation and clear priority
    cnt_clr = 1'b1;
    cycles(1);
    cnt_clr = 1'b0;
    for (int i = 0; i < 300; i++) send(1);
    drain();
    chk_eq("cnt_single_sat", 32'(cnt_single), 32'd255);
    chk_eq("cnt_double_zero", 32'(cnt_double), 32'd0);
    send(1);
    bus.in_valid = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 10) begin
      cycles(1);
      n++;
    end
    cnt_clr = 1'b1;
    cycles(1);
    cnt_clr = 1'b0;
    chk_eq("clr_priority", 32'(cnt_single), 32'd0);
    drain();
    send(1);
    send(3);
    drain();

    // Reset with two words in flight
    send(1);
    send(7);
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    chk_eq("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk_eq("midrst_in_ready", 32'(bus.in_ready), 32'd0);
    chk_eq("midrst_cnt_single", 32'(cnt_single), 32'd0);
    chk_eq("midrst_cnt_double", 32'(cnt_double), 32'd0);
    chk_eq("midrst_data", 32'(bus.data_out), 32'd0);
    cycles(2);
    @(negedge clk);
    #2 rst_n = 1'b1;
    #1 chk_eq("in_ready_release2", 32'(bus.in_ready), 32'd1);
    cycles(1);
    lat_chk = 1'b1;
    send(6);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

`default_nettype wire
